pe_mem_responder: RTL and testbench

PE_MEM_RESPONDER -- requirements
Module: pe_mem_responder

---
 rtl/pe_mem_pkg.sv | 20 ++
 rtl/pe_mem_array.sv | 40 ++++
 rtl/pe_mem_responder.sv | 114 +++++++++++
 tb/tb_pe_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_mem_pkg.sv
// Shared definitions for the PE memory responder: FSM states, default sizing
// and the helper that sizes the word index from the memory depth.
package pe_mem_pkg;

   localparam int DEFAULT_DEPTH   = 256;
   localparam int DEFAULT_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Never returns zero so a one-word memory still gets a legal index port.
   function automatic int word_index_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pe_mem_array.sv
// Synchronous single-port 32-bit RAM with per-byte write enables and a
// registered read port; only the read register is cleared by reset.
module pe_mem_array
   import pe_mem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = word_index_width(DEFAULT_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wstrb,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Read data only moves on a read access, so it holds between acks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= 32'd0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/pe_mem_responder.sv
// Memory responder for the PE controller: samples a held read/write request,
// performs the access after a fixed latency and answers with a one-cycle ack.
module pe_mem_responder
   import pe_mem_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ack,
   output logic [31:0] mem_Message,
   output logic        mem_error,
   output logic        mem_busy
);

   localparam int AW = word_index_width(DEPTH);

   state_t        state;
   state_t        state_next;
   logic [3:0]    cnt;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic          write_q;
   logic          err_q;
   logic          req_valid;
   logic          req_err;
   logic          access;

   assign req_valid = mem_read | mem_write;
   assign req_err   = (mem_read & mem_write)
                    | (mem_address[1:0] != 2'b00)
                    | ({2'b00, mem_address[31:2]} >= 32'(DEPTH));

   // The RAM is touched only on the edge that moves WAIT into ACK.
   assign access = (state == WAIT) && (cnt == 4'd0) && !err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request is captured once in IDLE; later input changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cnt     <= 4'(LATENCY - 1);
                  idx_q   <= mem_address[AW+1:2];
                  wdata_q <= mem_wdata;
                  wstrb_q <= mem_wstrb;
                  write_q <= mem_write;
                  err_q   <= req_err;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               cnt <= cnt;
            end
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (req_valid) state_next = WAIT;
         WAIT: if (cnt == 4'd0) state_next = ACK;
         ACK:  state_next = HOLD;
         HOLD: if (!req_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign mem_ack   = (state == ACK);
   assign mem_error = (state == ACK) && err_q;
   assign mem_busy  = (state != IDLE);

   pe_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .en    (access),
      .we    (write_q),
      .addr  (idx_q),
      .wdata (wdata_q),
      .wstrb (wstrb_q),
      .rdata (mem_Message)
   );

endmodule

// File: tb/tb_pe_mem_responder.sv
// Directed self-checking bench for pe_mem_responder with default DEPTH/LATENCY.
module tb_pe_mem_responder;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_Message;
   logic        mem_error;
   logic        mem_busy;

   int checks = 0;
   int errors = 0;

   pe_mem_responder #(
      .DEPTH   (256),
      .LATENCY (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ack     (mem_ack),
      .mem_Message (mem_Message),
      .mem_error   (mem_error),
      .mem_busy    (mem_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one request from a negedge, waits for the ack, drops the request
   // and returns two cycles later with the responder back in IDLE.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                output int lat, output logic err, output logic [31:0] msg,
                                output logic ack_after, output logic busy_after);
      int n;
      mem_read    = rd;
      mem_write   = wr;
      mem_address = addr;
      mem_wdata   = wdata;
      mem_wstrb   = wstrb;
      lat = -1;
      err = 1'b0;
      msg = 32'd0;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_ack) break;
      end
      if (n > 20) begin
         checkOutput("ack_timeout", 32'd0, 32'd1);
      end else begin
         lat = n - 1;
         err = mem_error;
         msg = mem_Message;
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      ack_after = mem_ack;
      @(negedge clk);
      busy_after = mem_busy;
   endtask

   int          lat;
   logic        err;
   logic [31:0] msg;
   logic        ack_after;
   logic        busy_after;
   int          ack_count;
   int          n;

   initial begin
      rst         = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = 32'd0;
      mem_wdata   = 32'd0;
      mem_wstrb   = 4'd0;
      #1;
      checkOutput("reset_ack",   {31'd0, mem_ack},   32'd0);
      checkOutput("reset_error", {31'd0, mem_error}, 32'd0);
      checkOutput("reset_busy",  {31'd0, mem_busy},  32'd0);
      checkOutput("reset_msg",   mem_Message,        32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full-word write, latency and single-cycle ack
      applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, err, msg, ack_after, busy_after);
      checkOutput("wr1_latency",   32'(lat), 32'd2);
      checkOutput("wr1_error",     {31'd0, err}, 32'd0);
      checkOutput("wr1_ack_pulse", {31'd0, ack_after}, 32'd0);
      checkOutput("wr1_idle",      {31'd0, busy_after}, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("rd1_latency", 32'(lat), 32'd2);
      checkOutput("rd1_error",   {31'd0, err}, 32'd0);
      checkOutput("rd1_data",    msg, 32'hDEADBEEF);

      // Byte-lane write leaves read data untouched
      applyStimulus(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, err, msg, ack_after, busy_after);
      checkOutput("wr2_msg_held", msg, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("rd2_data", msg, 32'hDEADBEAA);

      // Zero strobe write changes nothing
      applyStimulus(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("wr0_error", {31'd0, err}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("rd0_data", msg, 32'hDEADBEAA);

      // Error cases: misaligned, out of range, both request lines
      applyStimulus(1'b1, 1'b0, 32'h03, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("mis_latency", 32'(lat), 32'd2);
      checkOutput("mis_error",   {31'd0, err}, 32'd1);
      checkOutput("mis_msg",     msg, 32'hDEADBEAA);
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("oor_error", {31'd0, err}, 32'd1);
      checkOutput("oor_msg",   msg, 32'hDEADBEAA);
      applyStimulus(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b1111, lat, err, msg, ack_after, busy_after);
      checkOutput("both_error", {31'd0, err}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("both_mem", msg, 32'hDEADBEAA);
      checkOutput("both_rd_error", {31'd0, err}, 32'd0);

      // Last legal word
      applyStimulus(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, lat, err, msg, ack_after, busy_after);
      checkOutput("top_wr_error", {31'd0, err}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h3FC, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("top_rd_data", msg, 32'hCAFEF00D);

      // Held read is serviced once and keeps busy high
      mem_read    = 1'b1;
      mem_write   = 1'b0;
      mem_address = 32'h10;
      ack_count   = 0;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_ack) break;
      end
      if (n > 20) checkOutput("held_timeout", 32'd0, 32'd1);
      else ack_count++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mem_ack) ack_count++;
         checkOutput("held_busy", {31'd0, mem_busy}, 32'd1);
      end
      mem_read = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("held_ack_count", 32'(ack_count), 32'd1);
      checkOutput("held_released", {31'd0, mem_busy}, 32'd0);
      checkOutput("held_data", mem_Message, 32'hDEADBEAA);

      // Reset during WAIT aborts a write
      applyStimulus(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'b1111, lat, err, msg, ack_after, busy_after);
      checkOutput("pre_wr_error", {31'd0, err}, 32'd0);
      mem_write   = 1'b1;
      mem_address = 32'h20;
      mem_wdata   = 32'h12345678;
      mem_wstrb   = 4'b1111;
      @(negedge clk);
      checkOutput("abort_in_wait", {31'd0, mem_busy}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", {31'd0, mem_busy}, 32'd0);
      checkOutput("abort_msg",  mem_Message, 32'd0);
      mem_write = 1'b0;
      ack_count = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mem_ack) ack_count++;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mem_ack) ack_count++;
      end
      checkOutput("abort_no_ack", 32'(ack_count), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, lat, err, msg, ack_after, busy_after);
      checkOutput("abort_rd_data", msg, 32'h0BADF00D);
      checkOutput("abort_rd_latency", 32'(lat), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
